switch_debouncer: RTL

//   Conditions the raw slide-switch inputs (Cin, a0..a2, b0..b2) before they

---
 rtl/sw_pkg.sv | 21 ++
 rtl/debounce_bit.sv | 78 +++++++
 rtl/switch_debouncer.sv | 50 +++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared constants and helpers for the slide-switch conditioning stage.
package sw_pkg;

    localparam int unsigned N_SW_DEFAULT     = 7;
    localparam int unsigned DEBOUNCE_DEFAULT = 1_000_000;

    // Switch bit positions in sw_raw / sw_clean
    localparam int unsigned SW_CIN = 0;
    localparam int unsigned SW_B0  = 1;
    localparam int unsigned SW_B1  = 2;
    localparam int unsigned SW_B2  = 3;
    localparam int unsigned SW_A0  = 4;
    localparam int unsigned SW_A1  = 5;
    localparam int unsigned SW_A2  = 6;

    // Width of a counter that must reach cycles-1 (never less than one bit)
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-switch conditioner: 2-flop synchronizer, stability counter,
// clean level register and one-cycle rise/fall pulse registers.
module debounce_bit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic clean_o,
    output logic rise_o,
    output logic fall_o,
    output logic update_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             clean_q;
    logic             clean_d;
    logic             rise_q;
    logic             rise_d;
    logic             fall_q;
    logic             fall_d;

    // Bring the asynchronous switch level into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Count consecutive cycles the synchronized level disagrees with clean
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s2_q == clean_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d   = '0;
            clean_d = s2_q;
            rise_d  = s2_q;
            fall_d  = ~s2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Filter state and registered edge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean_o  = clean_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign update_c = rise_d | fall_d;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces the raw slide switches feeding the adder / seven-segment path
// and flags every clean-level edit with a one-cycle pulse.
module switch_debouncer
    import sw_pkg::*;
#(
    parameter int unsigned N_SW            = N_SW_DEFAULT,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_raw,
    output logic [N_SW-1:0] sw_clean,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic            sw_changed
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [N_SW-1:0] update_c;
    logic            changed_q;

    // One independent filter per switch
    for (genvar i = 0; i < N_SW; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (sw_raw[i]),
            .clean_o  (sw_clean[i]),
            .rise_o   (sw_rise[i]),
            .fall_o   (sw_fall[i]),
            .update_c (update_c[i])
        );
    end

    // Registered OR of next-cycle pulses so it lines up with sw_rise/sw_fall
    always_ff @(posedge clk) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |update_c;
        end
    end

    assign sw_changed = changed_q;

endmodule
